mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_pkg.sv | 30 +++
 rtl/mem_access_unit_lane_align.sv | 66 ++++++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit.
// - MEM_WORD / MEM_BYTE / MEM_HALF : access-width field from instruction decode
// - state_t                        : access FSM states
// - is_bad_access()                : misaligned or reserved-width detection
package mem_access_unit_pkg;

    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // An access that must not reach the bus: misaligned half/word or the
    // reserved width encoding.
    function automatic logic is_bad_access(input logic [1:0] op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            MEM_WORD: bad = (addr_lo != 2'b00);
            MEM_HALF: bad = addr_lo[0];
            MEM_BYTE: bad = 1'b0;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering for the data-memory access unit.
// Ports:
//   mem_op     in  2   access width
//   addr_lo    in  2   byte offset within the word
//   mem_ext    in  1   1 = sign-extend loads, 0 = zero-extend
//   wdata      in  32  right-justified store data
//   word       in  32  word read from the bus
//   be         out 4   byte enables (little-endian lanes), 0 for reserved width
//   lane_wdata out 32  store data replicated across all lanes
//   load_data  out 32  selected lane, extended to 32 bits
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic        mem_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[addr_lo];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0;
        load_data  = word;
        case (mem_op)
            MEM_BYTE: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = {{24{mem_ext & byte_sel[7]}}, byte_sel};
            end
            MEM_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = {{16{mem_ext & half_sel[15]}}, half_sel};
            end
            MEM_WORD: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                load_data  = word;
            end
            default: begin
                be         = 4'b0000;
                lane_wdata = 32'h0;
                load_data  = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential data-memory access unit: turns one datapath load/store into one
// word-aligned bus transaction and returns aligned, extended load data.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req                 access request, operands held stable until done
//   mem_op, mem_ext     access width and load extension
//   mem_write           1 = store, 0 = load
//   addr, wdata         byte address and right-justified store data
//   stall               pipeline hold while accepting or in flight
//   done, err           one-cycle completion pulse and its error flag
//   rdata               last successful load result
//   bus_req..bus_wdata  registered bus request fields
//   bus_ack, bus_rdata  bus completion and read word
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  mem_op,
    input  logic        mem_ext,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_reg;
    logic [1:0]    op_reg;
    logic          ext_reg;
    logic          we_reg;
    logic [1:0]    addr_lo_reg;
    logic [CW-1:0] tmo_reg;

    logic          idle;
    logic [1:0]    align_op;
    logic [1:0]    align_lo;
    logic          align_ext;
    logic [3:0]    be_lane;
    logic [31:0]   wdata_lane;
    logic [31:0]   load_data;

    assign idle  = (state_reg == ST_IDLE);
    assign stall = (idle & req) | (state_reg == ST_BUSY);

    // One aligner serves both directions: in IDLE it steers the live store
    // operands into the bus registers; in BUSY it extracts the load from the
    // latched operands, since the bus word only arrives then.
    assign align_op  = idle ? mem_op    : op_reg;
    assign align_lo  = idle ? addr[1:0] : addr_lo_reg;
    assign align_ext = idle ? mem_ext   : ext_reg;

    mem_lane_align u_align (
        .mem_op     (align_op),
        .addr_lo    (align_lo),
        .mem_ext    (align_ext),
        .wdata      (wdata),
        .word       (bus_rdata),
        .be         (be_lane),
        .lane_wdata (wdata_lane),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= MEM_WORD;
            ext_reg     <= 1'b0;
            we_reg      <= 1'b0;
            addr_lo_reg <= 2'b00;
            tmo_reg     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= 32'h0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        op_reg      <= mem_op;
                        ext_reg     <= mem_ext;
                        we_reg      <= mem_write;
                        addr_lo_reg <= addr[1:0];
                        tmo_reg     <= '0;
                        if (is_bad_access(mem_op, addr[1:0])) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            state_reg <= ST_BUSY;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_lane;
                            bus_wdata <= wdata_lane;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack is checked first so a late ack beats the timeout.
                    if (bus_ack) begin
                        state_reg <= ST_DONE;
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        if (!we_reg) begin
                            rdata <= load_data;
                        end
                    end else if (tmo_reg == CW'(TIMEOUT - 1)) begin
                        // This cycle is the TIMEOUT-th without ack.
                        state_reg <= ST_DONE;
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  mem_op = 2'b00;
    logic        mem_ext = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mem_op    (mem_op),
        .mem_ext   (mem_ext),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          len;   // expected bus_req-high cycles, 0 = not checked
    } exp_bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          issue;
    } exp_done_t;

    exp_bus_t    bus_q[$];
    exp_done_t   done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_delay = 0;   // ack in the n-th bus_req cycle, 0 = never
    logic [31:0] rd_model = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus responder
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                busy_cnt++;
                bus_ack = (ack_delay != 0) && (busy_cnt == ack_delay);
            end else begin
                busy_cnt = 0;
                bus_ack  = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit        prev_req;
        int        hi_len;
        int        cur_len;
        exp_bus_t  b;
        exp_done_t d;
        prev_req = 1'b0;
        hi_len   = 0;
        cur_len  = 0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev_req) begin
                hi_len = 0;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur_len = 0;
                    $display("FAIL unexpected_bus_req: got bus_req=1 expected 0 (addr %h)", bus_addr);
                end else begin
                    b = bus_q.pop_front();
                    cur_len = b.len;
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_be", {28'h0, bus_be}, {28'h0, b.be});
                    chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
                    chk("bus_wdata", bus_wdata, b.wdata);
                end
            end
            if (bus_req) hi_len++;
            if (!bus_req && prev_req && cur_len != 0)
                chk("bus_req_len", hi_len, cur_len);
            prev_req = bus_req;

            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (t=%0t)", $time);
                end else begin
                    d = done_q.pop_front();
                    chk("done_err", {31'h0, err}, {31'h0, d.err});
                    chk("done_rdata", rdata, d.rdata);
                    chk("done_latency", cyc - d.issue, d.lat);
                    chk("stall_in_done", {31'h0, stall}, 32'h0);
                end
            end
        end
    end

    task automatic do_access(input string tag, input logic [1:0] op, input logic ext,
                             input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] brd, input int dly, input logic exp_bus,
                             input logic [31:0] eaddr, input logic [3:0] ebe,
                             input logic [31:0] ewd, input logic eerr,
                             input logic upd, input logic [31:0] new_rd);
        exp_bus_t  b;
        exp_done_t d;
        bit        seen;
        int        blen;
        @(posedge clk);
        #1;
        ack_delay = dly;
        bus_rdata = brd;
        mem_op    = op;
        mem_ext   = ext;
        mem_write = we;
        addr      = a;
        wdata     = wd;
        req       = 1'b1;
        if (upd) rd_model = new_rd;
        blen = (dly == 0) ? TMO : dly;
        if (exp_bus) begin
            b.addr  = eaddr;
            b.be    = ebe;
            b.we    = we;
            b.wdata = ewd;
            b.len   = blen;
            bus_q.push_back(b);
        end
        d.err   = eerr;
        d.rdata = rd_model;
        d.lat   = exp_bus ? 1 + blen : 1;
        d.issue = cyc;
        done_q.push_back(d);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout_%s: got no done expected done within 40 cycles", tag);
        end
        $display("txn %-10s op=%0d we=%0d addr=%h -> err=%0d rdata=%h", tag, op, we, a, err, rdata);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    initial begin
        exp_bus_t b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //        tag          op        ext   we    addr          wdata         bus_rdata     dly bus   eaddr         be       ewd           err   upd   rdata
        do_access("LB",        MEM_BYTE, 1'b1, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        1'b0, 1'b1, 32'hFFFF_FF80);
        do_access("LHU",       MEM_HALF, 1'b0, 1'b0, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 1, 1'b1, 32'h0000_2000, 4'b1100, 32'h0,        1'b0, 1'b1, 32'h0000_BEEF);
        do_access("SB",        MEM_BYTE, 1'b0, 1'b1, 32'h0000_3001, 32'h0000_00A5, 32'hDEAD_BEEF, 2, 1'b1, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0);
        do_access("LW_mis",    MEM_WORD, 1'b0, 1'b0, 32'h0000_4002, 32'h0,        32'h1111_1111, 1, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 1'b0, 32'h0);
        do_access("RSV",       2'b11,    1'b0, 1'b0, 32'h0000_4000, 32'h0,        32'h1111_1111, 1, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 1'b0, 32'h0);
        do_access("LH_mis",    MEM_HALF, 1'b1, 1'b0, 32'h0000_4001, 32'h0,        32'h1111_1111, 1, 1'b0, 32'h0,         4'b0000, 32'h0,        1'b1, 1'b0, 32'h0);
        do_access("LW_tmo",    MEM_WORD, 1'b0, 1'b0, 32'h0000_5000, 32'h0,        32'h2222_2222, 0, 1'b1, 32'h0000_5000, 4'b1111, 32'h0,        1'b1, 1'b0, 32'h0);
        do_access("LW_ack16",  MEM_WORD, 1'b0, 1'b0, 32'h0000_5004, 32'h0,        32'h1234_5678, 16, 1'b1, 32'h0000_5004, 4'b1111, 32'h0,       1'b0, 1'b1, 32'h1234_5678);
        do_access("LH_hi",     MEM_HALF, 1'b1, 1'b0, 32'h0000_6002, 32'h0,        32'h8001_7FFF, 1, 1'b1, 32'h0000_6000, 4'b1100, 32'h0,        1'b0, 1'b1, 32'hFFFF_8001);
        do_access("SH",        MEM_HALF, 1'b0, 1'b1, 32'h0000_7002, 32'h1234_ABCD, 32'h0,        3, 1'b1, 32'h0000_7000, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0);
        do_access("SW",        MEM_WORD, 1'b0, 1'b1, 32'h0000_8000, 32'hCAFE_F00D, 32'h0,        1, 1'b1, 32'h0000_8000, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        do_access("LB_pos",    MEM_BYTE, 1'b1, 1'b0, 32'h0000_9001, 32'h0,        32'h0000_7F00, 1, 1'b1, 32'h0000_9000, 4'b0010, 32'h0,        1'b0, 1'b1, 32'h0000_007F);
        do_access("LH_lo",     MEM_HALF, 1'b1, 1'b0, 32'h0000_9000, 32'h0,        32'h1234_F00F, 1, 1'b1, 32'h0000_9000, 4'b0011, 32'h0,        1'b0, 1'b1, 32'hFFFF_F00F);
        do_access("LBU_0",     MEM_BYTE, 1'b0, 1'b0, 32'h0000_9000, 32'h0,        32'hAAAA_AA90, 1, 1'b1, 32'h0000_9000, 4'b0001, 32'h0,        1'b0, 1'b1, 32'h0000_0090);

        // Reset while BUSY: no done, bus released, stall low.
        @(posedge clk);
        #1;
        ack_delay = 0;
        mem_op    = MEM_WORD;
        mem_ext   = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0000_B000;
        wdata     = 32'h0;
        req       = 1'b1;
        b.addr  = 32'h0000_B000;
        b.be    = 4'b1111;
        b.we    = 1'b0;
        b.wdata = 32'h0;
        b.len   = 0;
        bus_q.push_back(b);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_model = 32'h0;
        @(negedge clk);
        chk("midrst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("midrst_stall", {31'h0, stall}, 32'h0);
        chk("midrst_done", {31'h0, done}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        $display("txn %-10s reset during BUSY -> bus_req=%0d stall=%0d", "RST_BUSY", bus_req, stall);
        repeat (4) @(negedge clk);

        do_access("LBU_after", MEM_BYTE, 1'b0, 1'b0, 32'h0000_A002, 32'h0,        32'h00C3_0000, 1, 1'b1, 32'h0000_A000, 4'b0100, 32'h0,        1'b0, 1'b1, 32'h0000_00C3);

        repeat (4) @(negedge clk);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
